// File: rtl/ff_bank_sequencer_if.sv
// ff_bank_sequencer_if
// Run-control and result bus of ff_bank_sequencer.
//   start          : run request (driven by the master)
//   busy / done    : controller status; done is a one-cycle pulse
//   step           : index of the current stimulus step
//   err_cnt        : saturating count of mismatching bits in the run
//   err_mask       : sticky per-cell failure flags {sr, jk, t, d}
//   first_err_step : step of the first mismatch (0 when logging is absent)
//   first_err_q    : {q_sr, q_jk, q_t, q_d} seen at the first mismatch
interface ff_bank_sequencer_if #(
   parameter int CNT_W = 8
);
   logic             start;
   logic             busy;
   logic             done;
   logic [7:0]       step;
   logic [CNT_W-1:0] err_cnt;
   logic [3:0]       err_mask;
   logic [7:0]       first_err_step;
   logic [3:0]       first_err_q;

   modport master (
      output start,
      input  busy, done, step, err_cnt, err_mask, first_err_step, first_err_q
   );

   modport slave (
      input  start,
      output busy, done, step, err_cnt, err_mask, first_err_step, first_err_q
   );
endinterface

// File: rtl/ff_bank_sequencer.sv
// ff_bank_sequencer
// Stimulus and checking engine for the D/T/JK/SR flip-flop bank. A start
// request clears the bank, then drives LFSR-derived inputs for STEPS steps,
// tracking a golden model of every cell and counting output mismatches.
// Ports:
//   clk, reset     : rising-edge clock, asynchronous active-low reset
//   bus (slave)    : start/busy/done handshake and run results
//   ff_rst         : active-high reset to the D, T and JK cells
//   d,t,j,k,s,r    : registered cell inputs
//   q_d,q_t,q_jk,q_sr : cell outputs
// Optional feature: define FFSEQ_ERR_LOG_EN to capture the step and the
// output vector of the first mismatch of each run; otherwise those result
// fields read as 0 and no capture logic exists.
module ff_bank_sequencer #(
   parameter logic [7:0] LFSR_SEED = 8'hA5,
   parameter int         STEPS     = 16,
   parameter int         CNT_W     = 8
) (
   input  logic               clk,
   input  logic               reset,
   ff_bank_sequencer_if.slave bus,
   output logic               ff_rst,
   output logic               d,
   output logic               t,
   output logic               j,
   output logic               k,
   output logic               s,
   output logic               r,
   input  logic               q_d,
   input  logic               q_t,
   input  logic               q_jk,
   input  logic               q_sr
);

   typedef enum logic [2:0] {IDLE, CLR, DRIVE, CHECK, DONE} state_t;

   state_t           state, state_nxt;
   logic             clr_second;
   logic [7:0]       lfsr, lfsr_nxt;
   logic [5:0]       cells;           // {r, s, k, j, t, d}
   logic [7:0]       step_r;
   logic [CNT_W-1:0] err_cnt_r;
   logic [3:0]       err_mask_r;
   logic             m_d, m_t, m_jk, m_sr, sr_valid;
   logic [3:0]       q_vec, mism;
   logic             last_step;

   // SR pair is forced away from 11 by masking r with ~s.
   function automatic logic [5:0] cells_from(input logic [7:0] l);
      return {l[5] & ~l[4], l[4], l[3], l[2], l[1], l[0]};
   endfunction

   function automatic logic [2:0] popcount4(input logic [3:0] v);
      return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [2:0]       b);
      logic [CNT_W+2:0] sum;
      sum = (CNT_W+3)'(a) + (CNT_W+3)'(b);
      if (sum[CNT_W+2:CNT_W] != 3'b000)
         return {CNT_W{1'b1}};
      return sum[CNT_W-1:0];
   endfunction

   assign last_step = (step_r == 8'(STEPS - 1));
   assign q_vec     = {q_sr, q_jk, q_t, q_d};
   // SR has no reset, so its output is meaningless until it has been written.
   assign mism      = {sr_valid & (q_sr ^ m_sr), q_jk ^ m_jk, q_t ^ m_t, q_d ^ m_d};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         clr_second <= 1'b0;
      end else begin
         state      <= state_nxt;
         clr_second <= (state == CLR) ? ~clr_second : 1'b0;
      end
   end

   always_comb begin
      state_nxt = state;
      lfsr_nxt  = lfsr;
      case (state)
         IDLE:  if (bus.start) state_nxt = CLR;
         CLR: begin
            lfsr_nxt = LFSR_SEED;
            if (clr_second) state_nxt = DRIVE;
         end
         DRIVE: state_nxt = CHECK;
         CHECK: begin
            lfsr_nxt  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            state_nxt = last_step ? DONE : DRIVE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Status is decoded from the state register so reset clears it at once.
   assign bus.busy = (state != IDLE);
   assign bus.done = (state == DONE);
   assign ff_rst   = (state == CLR);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lfsr       <= LFSR_SEED;
         cells      <= '0;
         step_r     <= '0;
         err_cnt_r  <= '0;
         err_mask_r <= '0;
         m_d        <= 1'b0;
         m_t        <= 1'b0;
         m_jk       <= 1'b0;
         m_sr       <= 1'b0;
         sr_valid   <= 1'b0;
      end else begin
         lfsr <= lfsr_nxt;
         // Cell inputs only move when entering CLR or DRIVE.
         if (state_nxt == CLR)
            cells <= '0;
         else if (state_nxt == DRIVE)
            cells <= cells_from(lfsr_nxt);
         case (state)
            CLR: begin
               step_r     <= '0;
               err_cnt_r  <= '0;
               err_mask_r <= '0;
               m_d        <= 1'b0;
               m_t        <= 1'b0;
               m_jk       <= 1'b0;
               m_sr       <= 1'b0;
               sr_valid   <= 1'b0;
            end
            // The bank captures these same inputs on this edge.
            DRIVE: begin
               m_d <= cells[0];
               m_t <= m_t ^ cells[1];
               case ({cells[2], cells[3]})
                  2'b10:   m_jk <= 1'b1;
                  2'b01:   m_jk <= 1'b0;
                  2'b11:   m_jk <= ~m_jk;
                  default: m_jk <= m_jk;
               endcase
               if (cells[4])
                  m_sr <= 1'b1;
               else if (cells[5])
                  m_sr <= 1'b0;
               if (cells[4] | cells[5])
                  sr_valid <= 1'b1;
            end
            CHECK: begin
               err_cnt_r  <= sat_add(err_cnt_r, popcount4(mism));
               err_mask_r <= err_mask_r | mism;
               if (!last_step)
                  step_r <= step_r + 8'd1;
            end
            default: ;
         endcase
      end
   end

   assign {r, s, k, j, t, d} = cells;
   assign bus.step     = step_r;
   assign bus.err_cnt  = err_cnt_r;
   assign bus.err_mask = err_mask_r;

`ifdef FFSEQ_ERR_LOG_EN
   logic [7:0] fe_step;
   logic [3:0] fe_q;

   // An all-clear err_mask means no earlier mismatch in this run.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fe_step <= '0;
         fe_q    <= '0;
      end else if (state == CLR) begin
         fe_step <= '0;
         fe_q    <= '0;
      end else if (state == CHECK && mism != 4'b0000 && err_mask_r == 4'b0000) begin
         fe_step <= step_r;
         fe_q    <= q_vec;
      end
   end

   assign bus.first_err_step = fe_step;
   assign bus.first_err_q    = fe_q;
`else
   assign bus.first_err_step = '0;
   assign bus.first_err_q    = '0;
`endif

endmodule

// File: tb/tb_ff_bank_sequencer.sv
// tb_ff_bank_sequencer
// Directed bench for ff_bank_sequencer. Two instances: A (seed A5, 16 steps,
// 8-bit count) and B (seed 01, 8 steps, 2-bit count). Each drives a
// behavioural flip-flop bank with per-cell stuck/invert fault controls.
// Expected values were worked out by hand from the LFSR sequence:
//   A5 4A 95 2A 54 A9 53 A7 4E 9D 3B 77 EE DD BB 76  (d=1 on 10 steps, first 0;
//   d=0 on 6 steps, first 1)
//   01 02 04 08 11 ...  (no s/r on steps 0-3, s=1 on step 4)
module tb_ff_bank_sequencer;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   ff_bank_sequencer_if #(.CNT_W(8)) bus_a ();
   ff_bank_sequencer_if #(.CNT_W(2)) bus_b ();

   logic ff_rst_a, d_a, t_a, j_a, k_a, s_a, r_a, q_d_a, q_t_a, q_jk_a, q_sr_a;
   logic ff_rst_b, d_b, t_b, j_b, k_b, s_b, r_b, q_d_b, q_t_b, q_jk_b, q_sr_b;

   ff_bank_sequencer #(.LFSR_SEED(8'hA5), .STEPS(16), .CNT_W(8)) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a), .ff_rst(ff_rst_a),
      .d(d_a), .t(t_a), .j(j_a), .k(k_a), .s(s_a), .r(r_a),
      .q_d(q_d_a), .q_t(q_t_a), .q_jk(q_jk_a), .q_sr(q_sr_a)
   );

   ff_bank_sequencer #(.LFSR_SEED(8'h01), .STEPS(8), .CNT_W(2)) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b), .ff_rst(ff_rst_b),
      .d(d_b), .t(t_b), .j(j_b), .k(k_b), .s(s_b), .r(r_b),
      .q_d(q_d_b), .q_t(q_t_b), .q_jk(q_jk_b), .q_sr(q_sr_b)
   );

   // Behavioural banks. They capture once per step (on the DRIVE cycle),
   // tracked by a phase bit that CLR realigns.
   logic [3:0] force_en_a = '0, force_val_a = '0, inv_a = '0;
   logic [3:0] force_en_b = '0, force_val_b = '0, inv_b = '0;
   logic bd_a = 1'b0, bt_a = 1'b0, bjk_a = 1'b0, bsr_a = 1'b0, ph_a = 1'b0;
   logic bd_b = 1'b0, bt_b = 1'b0, bjk_b = 1'b0, bsr_b = 1'b1, ph_b = 1'b0;
   logic cap_a, cap_b;

   assign cap_a = bus_a.busy & ~ff_rst_a & ~ph_a;
   assign cap_b = bus_b.busy & ~ff_rst_b & ~ph_b;

   always @(posedge clk) begin
      if (ff_rst_a) ph_a <= 1'b0;
      else if (bus_a.busy) ph_a <= ~ph_a;
      if (ff_rst_a) begin
         bd_a <= 1'b0; bt_a <= 1'b0; bjk_a <= 1'b0;
      end else if (cap_a) begin
         bd_a <= d_a;
         bt_a <= bt_a ^ t_a;
         case ({j_a, k_a})
            2'b10:   bjk_a <= 1'b1;
            2'b01:   bjk_a <= 1'b0;
            2'b11:   bjk_a <= ~bjk_a;
            default: bjk_a <= bjk_a;
         endcase
      end
      if (cap_a) begin
         if (s_a) bsr_a <= 1'b1;
         else if (r_a) bsr_a <= 1'b0;
      end
   end

   always @(posedge clk) begin
      if (ff_rst_b) ph_b <= 1'b0;
      else if (bus_b.busy) ph_b <= ~ph_b;
      if (ff_rst_b) begin
         bd_b <= 1'b0; bt_b <= 1'b0; bjk_b <= 1'b0;
      end else if (cap_b) begin
         bd_b <= d_b;
         bt_b <= bt_b ^ t_b;
         case ({j_b, k_b})
            2'b10:   bjk_b <= 1'b1;
            2'b01:   bjk_b <= 1'b0;
            2'b11:   bjk_b <= ~bjk_b;
            default: bjk_b <= bjk_b;
         endcase
      end
      if (cap_b) begin
         if (s_b) bsr_b <= 1'b1;
         else if (r_b) bsr_b <= 1'b0;
      end
   end

   assign {q_sr_a, q_jk_a, q_t_a, q_d_a} = (force_en_a & force_val_a) |
                                           (~force_en_a & ({bsr_a, bjk_a, bt_a, bd_a} ^ inv_a));
   assign {q_sr_b, q_jk_b, q_t_b, q_d_b} = (force_en_b & force_val_b) |
                                           (~force_en_b & ({bsr_b, bjk_b, bt_b, bd_b} ^ inv_b));

   logic [40:0] outs_a;
   logic [34:0] outs_b;
   assign outs_a = {bus_a.busy, bus_a.done, ff_rst_a, d_a, t_a, j_a, k_a, s_a, r_a, bus_a.step,
                    bus_a.err_cnt, bus_a.err_mask, bus_a.first_err_step, bus_a.first_err_q};
   assign outs_b = {bus_b.busy, bus_b.done, ff_rst_b, d_b, t_b, j_b, k_b, s_b, r_b, bus_b.step,
                    bus_b.err_cnt, bus_b.err_mask, bus_b.first_err_step, bus_b.first_err_q};

   bit         sel = 1'b0;
   logic       m_busy, m_done, m_ffrst;
   logic [5:0] m_cin;
   assign m_busy  = sel ? bus_b.busy : bus_a.busy;
   assign m_done  = sel ? bus_b.done : bus_a.done;
   assign m_ffrst = sel ? ff_rst_b : ff_rst_a;
   assign m_cin   = sel ? {r_b, s_b, k_b, j_b, t_b, d_b} : {r_a, s_a, k_a, j_a, t_a, d_a};

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // One start pulse, then observe cycles 1.. until done (bounded).
   task automatic run_once(input bit which, output int done_cyc, output int busy_cnt,
                           output int ffrst_cnt, output logic [5:0] cin_c1,
                           output logic [5:0] cin_c3, output logic [5:0] cin_c4);
      sel = which;
      done_cyc = -1; busy_cnt = 0; ffrst_cnt = 0;
      cin_c1 = '0; cin_c3 = '0; cin_c4 = '0;
      @(negedge clk);
      if (which) bus_b.start = 1'b1; else bus_a.start = 1'b1;
      @(posedge clk); #1;
      bus_a.start = 1'b0; bus_b.start = 1'b0;
      for (int cyc = 1; cyc <= 200 && done_cyc < 0; cyc++) begin
         @(negedge clk);
         if (m_busy) busy_cnt++;
         if (m_ffrst) ffrst_cnt++;
         if (cyc == 1) cin_c1 = m_cin;
         if (cyc == 3) cin_c3 = m_cin;
         if (cyc == 4) cin_c4 = m_cin;
         if (m_done) done_cyc = cyc;
      end
   endtask

   int         dc, bc, fc, done_cnt;
   logic [5:0] c1, c3, c4;
   logic       b36, f37, saw_done;

   initial begin
      bus_a.start = 1'b0;
      bus_b.start = 1'b0;
      #2 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("reset_outs_a", 64'(outs_a), 64'd0);
      check_val("reset_outs_b", 64'(outs_b), 64'd0);
      @(negedge clk) reset = 1'b1;

      // SR bank powered up at 1; no s/r on steps 0-3 must not count.
      run_once(1'b1, dc, bc, fc, c1, c3, c4);
      check_val("b_sr_done_cyc", 64'(dc), 64'd19);
      check_val("b_sr_err_cnt", 64'(bus_b.err_cnt), 64'd0);
      check_val("b_sr_err_mask", 64'(bus_b.err_mask), 64'd0);

      // All cells faulted: 28 raw bits saturate at 3.
      inv_b = 4'hF;
      run_once(1'b1, dc, bc, fc, c1, c3, c4);
      check_val("b_sat_err_cnt", 64'(bus_b.err_cnt), 64'd3);
      check_val("b_sat_err_mask", 64'(bus_b.err_mask), 64'hF);
      inv_b = 4'h0;

      // Fault-free run on A.
      run_once(1'b0, dc, bc, fc, c1, c3, c4);
      check_val("a_done_cyc", 64'(dc), 64'd35);
      check_val("a_busy_cycles", 64'(bc), 64'd35);
      check_val("a_ffrst_cycles", 64'(fc), 64'd2);
      check_val("a_cin_clr", 64'(c1), 64'h00);
      check_val("a_cin_drive0", 64'(c3), 64'h25);
      check_val("a_cin_check0", 64'(c4), 64'h25);
      check_val("a_err_cnt", 64'(bus_a.err_cnt), 64'd0);
      check_val("a_err_mask", 64'(bus_a.err_mask), 64'd0);
      check_val("a_final_step", 64'(bus_a.step), 64'd15);

      // D output stuck at 0.
      force_en_a = 4'b0001; force_val_a = 4'b0000;
      run_once(1'b0, dc, bc, fc, c1, c3, c4);
      check_val("d0_err_cnt", 64'(bus_a.err_cnt), 64'd10);
      check_val("d0_err_mask", 64'(bus_a.err_mask), 64'h1);
`ifdef FFSEQ_ERR_LOG_EN
      check_val("d0_first_step", 64'(bus_a.first_err_step), 64'd0);
      check_val("d0_first_q", 64'(bus_a.first_err_q), 64'h4);
`else
      check_val("d0_first_step", 64'(bus_a.first_err_step), 64'd0);
      check_val("d0_first_q", 64'(bus_a.first_err_q), 64'h0);
`endif

      // D output stuck at 1.
      force_val_a = 4'b0001;
      run_once(1'b0, dc, bc, fc, c1, c3, c4);
      check_val("d1_err_cnt", 64'(bus_a.err_cnt), 64'd6);
      check_val("d1_err_mask", 64'(bus_a.err_mask), 64'h1);
`ifdef FFSEQ_ERR_LOG_EN
      check_val("d1_first_step", 64'(bus_a.first_err_step), 64'd1);
      check_val("d1_first_q", 64'(bus_a.first_err_q), 64'h3);
`else
      check_val("d1_first_step", 64'(bus_a.first_err_step), 64'd0);
      check_val("d1_first_q", 64'(bus_a.first_err_q), 64'h0);
`endif
      force_en_a = 4'b0000; force_val_a = 4'b0000;

      // start held high: one done, IDLE in cycle 36, new CLR in cycle 37.
      sel = 1'b0; done_cnt = 0; b36 = 1'b1; f37 = 1'b0;
      @(negedge clk) bus_a.start = 1'b1;
      @(posedge clk); #1;
      for (int cyc = 1; cyc <= 37; cyc++) begin
         @(negedge clk);
         if (cyc <= 35 && bus_a.done) done_cnt++;
         if (cyc == 36) b36 = bus_a.busy;
         if (cyc == 37) f37 = ff_rst_a;
      end
      bus_a.start = 1'b0;
      check_val("hold_done_pulses", 64'(done_cnt), 64'd1);
      check_val("hold_idle_c36", 64'(b36), 64'd0);
      check_val("hold_clr_c37", 64'(f37), 64'd1);
      saw_done = 1'b0;
      for (int cyc = 0; cyc < 100 && !saw_done; cyc++) begin
         @(negedge clk);
         if (bus_a.done) saw_done = 1'b1;
      end
      check_val("hold_second_done", 64'(saw_done), 64'd1);

      // Reset pulled during step 5 (DRIVE in cycle 13).
      @(negedge clk) bus_a.start = 1'b1;
      @(posedge clk); #1;
      bus_a.start = 1'b0;
      for (int cyc = 1; cyc <= 13; cyc++) @(negedge clk);
      check_val("abort_step_before", 64'(bus_a.step), 64'd5);
      reset = 1'b0;
      #1;
      check_val("abort_outs_zero", 64'(outs_a), 64'd0);
      saw_done = 1'b0;
      for (int cyc = 0; cyc < 3; cyc++) begin
         @(negedge clk);
         if (bus_a.done) saw_done = 1'b1;
      end
      reset = 1'b1;
      for (int cyc = 0; cyc < 5; cyc++) begin
         @(negedge clk);
         if (bus_a.done) saw_done = 1'b1;
      end
      check_val("abort_no_done", 64'(saw_done), 64'd0);
      run_once(1'b0, dc, bc, fc, c1, c3, c4);
      check_val("after_abort_done_cyc", 64'(dc), 64'd35);
      check_val("after_abort_err_cnt", 64'(bus_a.err_cnt), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
